unidade_muldiv: RTL

- Multi-cycle multiply/divide sequencer. It takes the `*` and `/` operations off the combinational ALU path and performs them iteratively over WIDTH cycles.
- It sits beside the ALU in the execute stage. The main control FSM starts it and stalls the pipeline while Busy is high.
- Results go to Output_Lo/Output_Hi and are held there for the HI/LO register write-back.

---
 rtl/unidade_muldiv_if.sv | 48 ++++
 rtl/unidade_muldiv.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/unidade_muldiv_if.sv
// -----------------------------------------------------------------------------
// unidade_muldiv_if
// Bundles the request and result signals of the multi-cycle multiply/divide
// unit. Clock and reset stay plain ports on the unit itself.
//
// Handshake (valid/ready): Start is the request "valid". The unit is "ready"
// whenever it is idle or in its Done cycle (Busy = 0). A request is accepted on
// the rising edge where Start = 1 and the unit is ready. Op/Input_1/Input_2 are
// captured on that edge and may change freely afterwards. Start while Busy = 1
// is dropped, not queued. Done is a one-cycle "result valid" pulse with no
// back-pressure. Output_Lo/Output_Hi hold the last result until the next one.
//
// Signals:
//   Start      request pulse                     (master -> slave)
//   Op         0 = unsigned multiply, 1 = divide (master -> slave)
//   Input_1    multiplicand / dividend           (master -> slave)
//   Input_2    multiplier / divisor              (master -> slave)
//   Output_Lo  product low half / quotient       (slave -> master)
//   Output_Hi  product high half / remainder     (slave -> master)
//   Busy       operation in progress, stall      (slave -> master)
//   Done       one-cycle result-valid pulse      (slave -> master)
//   Div_Zero   divisor was zero, Done cycle only (slave -> master)
//   dbg_state  FSM state for observation         (slave -> master)
// -----------------------------------------------------------------------------
interface unidade_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Op;
  logic [WIDTH-1:0] Input_1;
  logic [WIDTH-1:0] Input_2;
  logic [WIDTH-1:0] Output_Lo;
  logic [WIDTH-1:0] Output_Hi;
  logic             Busy;
  logic             Done;
  logic             Div_Zero;
  logic [1:0]       dbg_state;

  modport master (
    output Start, Op, Input_1, Input_2,
    input  Output_Lo, Output_Hi, Busy, Done, Div_Zero, dbg_state
  );

  modport slave (
    input  Start, Op, Input_1, Input_2,
    output Output_Lo, Output_Hi, Busy, Done, Div_Zero, dbg_state
  );
endinterface

// File: rtl/unidade_muldiv.sv
// -----------------------------------------------------------------------------
// unidade_muldiv
// Multi-cycle unsigned multiply/divide sequencer placed beside the ALU in the
// execute stage. Multiply uses shift-add, divide uses restoring division; both
// take WIDTH iterations. Divide by zero short-cuts straight to the Done cycle.
//
// Ports:
//   clock  system clock, rising-edge
//   reset  synchronous, active-high; aborts any operation, clears outputs
//   bus    unidade_muldiv_if.slave (Start/Op/Input_1/Input_2 in,
//          Output_Lo/Output_Hi/Busy/Done/Div_Zero/dbg_state out)
// -----------------------------------------------------------------------------
module unidade_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  unidade_muldiv_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIM  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [CW-1:0]    r_cnt;
  logic             r_op;
  // Multiplicand for multiply, divisor for divide.
  logic [WIDTH-1:0] r_operand;
  // Working accumulator: {Hi,Lo} = {partial product, multiplier} for
  // multiply, {remainder, quotient} for divide.
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_out_lo;
  logic [WIDTH-1:0] r_out_hi;
  logic             r_div_zero;

  logic             w_ready;
  logic             w_accept;
  logic             w_div0;
  logic             w_busy;
  logic             w_done;
  logic             w_last_iter;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  logic [WIDTH:0]   w_shift_rem;
  logic [WIDTH-1:0] w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;
  logic [WIDTH-1:0] w_iter_hi;
  logic [WIDTH-1:0] w_iter_lo;

  // A new request is taken in IDLE and also in the Done cycle, so
  // back-to-back operations need no bubble.
  assign w_ready     = (r_state == S_IDLE) || (r_state == S_FIM);
  assign w_accept    = w_ready && bus.Start;
  assign w_div0      = bus.Op && (bus.Input_2 == '0);
  assign w_last_iter = (r_cnt == CW'(1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = w_div0 ? S_FIM : S_CALC;
        end
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (w_last_iter) begin
          w_next_state = S_FIM;
        end
      end
      S_FIM: begin
        w_done = 1'b1;
        if (w_accept) begin
          w_next_state = w_div0 ? S_FIM : S_CALC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // One iteration of each algorithm, computed from the current accumulator.
  // ---------------------------------------------------------------------------
  // Shift-add: conditionally add multiplicand into Hi (carry lands in bit
  // WIDTH), then shift {carry,Hi,Lo} right by one.
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_operand} : '0);
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};

  // Restoring divide: shift {rem,quot} left, then try rem - divisor. The
  // shifted remainder needs WIDTH+1 bits for the comparison; when the trial
  // succeeds the result is below the divisor, so WIDTH bits hold it.
  assign w_shift_rem = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_ge        = (w_shift_rem >= {1'b0, r_operand});
  assign w_trial     = w_shift_rem[WIDTH-1:0] - r_operand;
  assign w_div_hi    = w_ge ? w_trial : w_shift_rem[WIDTH-1:0];
  assign w_div_lo    = {r_acc_lo[WIDTH-2:0], w_ge};

  assign w_iter_hi = r_op ? w_div_hi : w_mul_hi;
  assign w_iter_lo = r_op ? w_div_lo : w_mul_lo;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt      <= '0;
      r_op       <= 1'b0;
      r_operand  <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_out_lo   <= '0;
      r_out_hi   <= '0;
      r_div_zero <= 1'b0;
    end else begin
      // Div_Zero is only ever high for the single Done cycle that follows a
      // divide-by-zero accept.
      r_div_zero <= 1'b0;
      if (w_accept) begin
        r_op      <= bus.Op;
        r_operand <= bus.Op ? bus.Input_2 : bus.Input_1;
        r_acc_hi  <= '0;
        r_acc_lo  <= bus.Op ? bus.Input_1 : bus.Input_2;
        r_cnt     <= CW'(WIDTH);
        if (w_div0) begin
          r_out_lo   <= '1;
          r_out_hi   <= bus.Input_1;
          r_div_zero <= 1'b1;
        end
      end else if (r_state == S_CALC) begin
        r_acc_hi <= w_iter_hi;
        r_acc_lo <= w_iter_lo;
        r_cnt    <= r_cnt - CW'(1);
        // Outputs only see the final iteration; intermediate values stay in
        // the accumulator.
        if (w_last_iter) begin
          r_out_hi <= w_iter_hi;
          r_out_lo <= w_iter_lo;
        end
      end
    end
  end

  assign bus.Output_Lo = r_out_lo;
  assign bus.Output_Hi = r_out_hi;
  assign bus.Busy      = w_busy;
  assign bus.Done      = w_done;
  assign bus.Div_Zero  = r_div_zero;
  assign bus.dbg_state = r_state;

endmodule
